// File: rtl/plru_way_alloc_pkg.sv
// Shared types and tree-indexing helper for the PLRU way allocator.
package plru_way_alloc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESP  = 2'd1,
      FLUSH = 2'd2
   } state_e;

   // Heap index of the node at depth 'level' on the root-to-'way' path.
   function automatic int node_idx(input int level, input int way, input int idx_w);
      return (1 << level) - 1 + (way >> (idx_w - level));
   endfunction

endpackage

// File: rtl/plru_lock_sel.sv
// Victim selection: lowest invalid unlocked way first, else a lock-aware PLRU walk.
// Purely combinational; o_cand is low when every way is locked.
module plru_lock_sel #(
   parameter  int NumWays = 8,
   localparam int IdxW    = $clog2(NumWays)
) (
   input  logic [NumWays-2:0] i_tree,
   input  logic [NumWays-1:0] i_valid,
   input  logic [NumWays-1:0] i_lock,
   output logic [NumWays-1:0] o_way,
   output logic [IdxW-1:0]    o_idx,
   output logic               o_evict,
   output logic               o_cand
);

   always_comb begin
      logic [2*NumWays-2:0] lk;
      logic                 found;
      logic                 go_r;
      int                   free_w;
      int                   n;
      int                   nn;

      lk     = '0;
      found  = 1'b0;
      go_r   = 1'b0;
      free_w = 0;
      n      = 0;
      nn     = 0;

      // lk[k] is set when every way under heap node k is locked.
      for (int w = 0; w < NumWays; w++) begin
         lk[NumWays-1+w] = i_lock[w];
      end
      for (int k = NumWays-2; k >= 0; k--) begin
         lk[k] = lk[2*k+1] & lk[2*k+2];
      end

      for (int w = 0; w < NumWays; w++) begin
         if (!found && !i_valid[w] && !i_lock[w]) begin
            found  = 1'b1;
            free_w = w;
         end
      end

      for (int l = 0; l < IdxW; l++) begin
         nn = n;
         for (int k = 0; k < NumWays-1; k++) begin
            if (k == n) begin
               go_r = i_tree[k] ? !lk[2*k+2] : lk[2*k+1];
               nn   = 2*k + 1 + (go_r ? 1 : 0);
            end
         end
         n = nn;
      end

      o_cand  = !lk[0];
      o_evict = !found;
      o_idx   = found ? IdxW'(free_w) : IdxW'(n - (NumWays-1));
      o_way   = '0;
      for (int w = 0; w < NumWays; w++) begin
         if (IdxW'(w) == o_idx) o_way[w] = 1'b1;
      end
   end

endmodule

// File: rtl/plru_way_alloc.sv
// PLRU way allocator: accept in cycle N gives a response in N+1, one per cycle back-to-back.
// Response held until alloc_rsp_ready_i; requests are refused while all ways are locked or a flush is due.
module plru_way_alloc
   import plru_way_alloc_pkg::*;
#(
   parameter  int NumWays = 8,
   localparam int IdxW    = $clog2(NumWays)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               alloc_req_valid_i,
   output logic               alloc_req_ready_o,
   output logic               alloc_rsp_valid_o,
   input  logic               alloc_rsp_ready_i,
   output logic [NumWays-1:0] alloc_way_o,
   output logic [IdxW-1:0]    alloc_idx_o,
   output logic               alloc_evict_o,
   input  logic               hit_valid_i,
   input  logic [NumWays-1:0] hit_way_i,
   input  logic               inval_valid_i,
   input  logic [NumWays-1:0] inval_way_i,
   input  logic [NumWays-1:0] lock_i,
   output logic [NumWays-1:0] valid_o,
   output logic               busy_o
);

   state_e             r_state, w_state_nxt;
   logic [NumWays-2:0] r_tree, w_tree_nxt;
   logic [NumWays-1:0] r_valid, w_valid_nxt;
   logic               r_flush_pend;
   logic [NumWays-1:0] r_way;
   logic [IdxW-1:0]    r_idx;
   logic               r_evict;

   logic [NumWays-1:0] w_sel_way;
   logic [IdxW-1:0]    w_sel_idx;
   logic               w_sel_evict;
   logic               w_sel_cand;
   logic               w_accept;
   logic               w_rsp_hs;
   logic               w_hit_ok;
   logic [IdxW-1:0]    w_hit_idx;

   plru_lock_sel #(.NumWays(NumWays)) u_sel (
      .i_tree  (r_tree),
      .i_valid (r_valid),
      .i_lock  (lock_i),
      .o_way   (w_sel_way),
      .o_idx   (w_sel_idx),
      .o_evict (w_sel_evict),
      .o_cand  (w_sel_cand)
   );

   // Point every node on the path to idx away from it.
   function automatic logic [NumWays-2:0] touch(input logic [NumWays-2:0] tree,
                                                input logic [IdxW-1:0]    idx);
      logic [NumWays-2:0] t;
      t = tree;
      for (int l = 0; l < IdxW; l++) begin
         for (int k = 0; k < NumWays-1; k++) begin
            if (k == node_idx(l, int'(idx), IdxW)) t[k] = ~idx[IdxW-1-l];
         end
      end
      return t;
   endfunction

   always_comb begin
      w_hit_idx = '0;
      for (int w = 0; w < NumWays; w++) begin
         if (hit_way_i[w]) w_hit_idx = IdxW'(w);
      end
   end

   assign w_hit_ok = hit_valid_i && |(hit_way_i & r_valid);
   assign w_accept = alloc_req_valid_i && alloc_req_ready_o;
   assign w_rsp_hs = alloc_rsp_valid_o && alloc_rsp_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (flush_i)       w_state_nxt = FLUSH;
            else if (w_accept) w_state_nxt = RESP;
         end
         RESP: begin
            if (w_rsp_hs) begin
               if (r_flush_pend || flush_i) w_state_nxt = FLUSH;
               else if (w_accept)           w_state_nxt = RESP;
               else                         w_state_nxt = IDLE;
            end
         end
         FLUSH:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      alloc_req_ready_o = 1'b0;
      alloc_rsp_valid_o = 1'b0;
      busy_o            = 1'b0;
      case (r_state)
         IDLE: alloc_req_ready_o = w_sel_cand && !flush_i;
         RESP: begin
            alloc_rsp_valid_o = 1'b1;
            alloc_req_ready_o = alloc_rsp_ready_i && w_sel_cand && !r_flush_pend && !flush_i;
         end
         FLUSH:   busy_o = 1'b1;
         default: ;
      endcase
   end

   // Hit touch first so the allocation owns any shared nodes; allocation beats a same-way inval.
   always_comb begin
      w_tree_nxt  = r_tree;
      w_valid_nxt = r_valid;
      if (r_state == FLUSH) begin
         w_tree_nxt  = '0;
         w_valid_nxt = '0;
      end else begin
         if (w_hit_ok)      w_tree_nxt  = touch(w_tree_nxt, w_hit_idx);
         if (inval_valid_i) w_valid_nxt = w_valid_nxt & ~inval_way_i;
         if (w_accept) begin
            w_tree_nxt  = touch(w_tree_nxt, w_sel_idx);
            w_valid_nxt = w_valid_nxt | w_sel_way;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tree       <= '0;
         r_valid      <= '0;
         r_flush_pend <= 1'b0;
         r_way        <= '0;
         r_idx        <= '0;
         r_evict      <= 1'b0;
      end else begin
         r_tree  <= w_tree_nxt;
         r_valid <= w_valid_nxt;
         if (r_state == FLUSH)                r_flush_pend <= 1'b0;
         else if (r_state == RESP && flush_i) r_flush_pend <= 1'b1;
         if (w_accept) begin
            r_way   <= w_sel_way;
            r_idx   <= w_sel_idx;
            r_evict <= w_sel_evict;
         end
      end
   end

   assign alloc_way_o   = r_way;
   assign alloc_idx_o   = r_idx;
   assign alloc_evict_o = r_evict;
   assign valid_o       = r_valid;

`ifndef SYNTHESIS
   a_pow2: assert property (@(posedge clk_i)
      (NumWays >= 2) && ((NumWays & (NumWays-1)) == 0));
   a_hit_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      hit_valid_i |-> $onehot(hit_way_i));
   a_inval_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      inval_valid_i |-> $onehot(inval_way_i));
   a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (alloc_rsp_valid_o && !alloc_rsp_ready_i) |=>
         (alloc_rsp_valid_o && $stable(alloc_way_o) && $stable(alloc_idx_o) && $stable(alloc_evict_o)));
`endif

endmodule

// File: tb/tb_plru_way_alloc.sv
// Bench for plru_way_alloc (4 ways): range-based PLRU reference model plus directed and random traffic.
module tb_plru_way_alloc;
   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b1;
   logic          flush_i = 1'b0;
   logic          req_v = 1'b0;
   logic          rsp_rdy = 1'b0;
   logic          hit_v = 1'b0;
   logic [N-1:0]  hit_way = 4'b0001;
   logic          inval_v = 1'b0;
   logic [N-1:0]  inval_way = 4'b0001;
   logic [N-1:0]  lock = '0;
   logic          req_rdy, rsp_v, evict_o, busy_o;
   logic [N-1:0]  way_o, valid_o;
   logic [IW-1:0] idx_o;

   plru_way_alloc #(.NumWays(N)) dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .flush_i           (flush_i),
      .alloc_req_valid_i (req_v),
      .alloc_req_ready_o (req_rdy),
      .alloc_rsp_valid_o (rsp_v),
      .alloc_rsp_ready_i (rsp_rdy),
      .alloc_way_o       (way_o),
      .alloc_idx_o       (idx_o),
      .alloc_evict_o     (evict_o),
      .hit_valid_i       (hit_v),
      .hit_way_i         (hit_way),
      .inval_valid_i     (inval_v),
      .inval_way_i       (inval_way),
      .lock_i            (lock),
      .valid_o           (valid_o),
      .busy_o            (busy_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: state 0 idle, 1 responding, 2 flushing; tree nodes as a heap of direction bits.
   int       m_state = 0;
   bit [N-1:0] m_valid = '0;
   bit       m_tree [0:N-2];
   bit       m_fp = 0;
   int       m_idx = 0;
   bit       m_evict = 0;
   int       q_idx [$];
   bit       q_ev [$];

   function automatic bit range_locked(input int lo, input int hi);
      for (int i = lo; i < hi; i++) if (!lock[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_select(output bit cand, output int idx, output bit ev);
      int lo, hi, mid, node;
      cand = (lock != {N{1'b1}});
      ev   = 1'b0;
      idx  = -1;
      for (int w = 0; w < N; w++) if (idx < 0 && !m_valid[w] && !lock[w]) idx = w;
      if (idx >= 0) return;
      ev = 1'b1; lo = 0; hi = N; node = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if ((m_tree[node] && !range_locked(mid, hi)) || (!m_tree[node] && range_locked(lo, mid))) begin
            lo = mid; node = 2*node + 2;
         end else begin
            hi = mid; node = 2*node + 1;
         end
      end
      idx = lo;
   endtask

   task automatic m_touch(input int w);
      int lo, hi, mid, node;
      lo = 0; hi = N; node = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (w < mid) begin m_tree[node] = 1'b1; hi = mid; node = 2*node + 1; end
         else         begin m_tree[node] = 1'b0; lo = mid; node = 2*node + 2; end
      end
   endtask

   task automatic m_clear();
      m_valid = '0;
      for (int k = 0; k < N-1; k++) m_tree[k] = 1'b0;
   endtask

   always @(negedge clk) begin
      bit cand, ev, exp_rdy, acc, hs, fp_old;
      int sel, hidx;
      if (!rst_ni) begin
         m_state = 0; m_fp = 0; m_idx = 0; m_evict = 0;
         m_clear();
         check("rst_rsp_valid", 32'(rsp_v), 0);
         check("rst_valid_o", 32'(valid_o), 0);
         check("rst_busy", 32'(busy_o), 0);
         check("rst_way", 32'(way_o), 0);
         check("rst_idx", 32'(idx_o), 0);
         check("rst_evict", 32'(evict_o), 0);
      end else begin
         m_select(cand, sel, ev);
         exp_rdy = (m_state == 0) ? (cand && !flush_i) :
                   (m_state == 1) ? (rsp_rdy && cand && !m_fp && !flush_i) : 1'b0;
         check("req_ready", 32'(req_rdy), 32'(exp_rdy));
         check("rsp_valid", 32'(rsp_v), 32'(m_state == 1));
         check("busy", 32'(busy_o), 32'(m_state == 2));
         check("valid_o", 32'(valid_o), 32'(m_valid));
         if (m_state == 1) begin
            check("rsp_idx", 32'(idx_o), 32'(m_idx));
            check("rsp_way", 32'(way_o), 32'(1) << m_idx);
            check("rsp_evict", 32'(evict_o), 32'(m_evict));
         end
         acc = req_v && exp_rdy;
         if (m_state == 2) begin
            m_clear(); m_fp = 0; m_state = 0;
         end else begin
            hs     = (m_state == 1) && rsp_rdy;
            fp_old = m_fp;
            if (hs) begin q_idx.push_back(m_idx); q_ev.push_back(m_evict); end
            hidx = 0;
            for (int w = 0; w < N; w++) if (hit_way[w]) hidx = w;
            if (hit_v && m_valid[hidx]) m_touch(hidx);
            if (inval_v) m_valid = m_valid & ~inval_way;
            if (acc) begin
               m_touch(sel); m_valid[sel] = 1'b1; m_idx = sel; m_evict = ev;
            end
            if (m_state == 0) begin
               m_state = flush_i ? 2 : (acc ? 1 : 0);
            end else begin
               if (flush_i) m_fp = 1;
               if (hs) m_state = (fp_old || flush_i) ? 2 : (acc ? 1 : 0);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_req(input int n);
      int cnt = 0;
      int budget = 0;
      req_v = 1'b1;
      while (cnt < n && budget < 50) begin
         @(negedge clk);
         if (req_rdy) cnt++;
         budget++;
         step();
      end
      req_v = 1'b0;
      check("req_accept_count", 32'(cnt), 32'(n));
   endtask

   task automatic do_reset();
      #2 rst_ni = 1'b0;
      req_v = 0; flush_i = 0; hit_v = 0; inval_v = 0; lock = '0;
      idle(2);
      rst_ni = 1'b1;
      q_idx.delete(); q_ev.delete();
   endtask

   initial begin
      logic [IW-1:0] held_idx;
      #2 rst_ni = 1'b0;
      idle(2);
      rst_ni = 1'b1;
      rsp_rdy = 1'b1;

      // Fill from empty, then two PLRU evictions.
      do_req(4); idle(3);
      check("s1_count", 32'(q_idx.size()), 4);
      for (int i = 0; i < 4; i++) begin
         check("s1_idx", 32'(q_idx[i]), 32'(i));
         check("s1_evict", 32'(q_ev[i]), 0);
      end
      @(negedge clk); check("s1_valid_all", 32'(valid_o), 32'hF); step();
      do_req(2); idle(3);
      check("s2_idx0", 32'(q_idx[4]), 0); check("s2_ev0", 32'(q_ev[4]), 1);
      check("s2_idx1", 32'(q_idx[5]), 2); check("s2_ev1", 32'(q_ev[5]), 1);

      // Locked way 0 is skipped.
      do_reset(); do_req(4); idle(3);
      lock = 4'b0001; do_req(1); lock = '0; idle(3);
      check("s3_idx", 32'(q_idx[4]), 1); check("s3_ev", 32'(q_ev[4]), 1);

      // Fully locked: nothing accepted.
      do_reset(); do_req(4); idle(3);
      lock = 4'b1111; req_v = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("s4_ready_low", 32'(req_rdy), 0);
         check("s4_no_rsp", 32'(rsp_v), 0);
         step();
      end
      lock = '0; do_req(1); idle(3);
      check("s4_idx", 32'(q_idx[4]), 0); check("s4_ev", 32'(q_ev[4]), 1);

      // Stalled response with a flush arriving mid-stall.
      rsp_rdy = 1'b0; do_req(1);
      @(negedge clk); held_idx = idx_o; step();
      flush_i = 1'b1; step(); flush_i = 1'b0; step();
      @(negedge clk);
      check("s5_rsp_held", 32'(rsp_v), 1);
      check("s5_idx_stable", 32'(idx_o), 32'(held_idx));
      check("s5_idx", 32'(idx_o), 2);
      check("s5_no_busy_yet", 32'(busy_o), 0);
      rsp_rdy = 1'b1; step();
      @(negedge clk); check("s5_busy", 32'(busy_o), 1); step();
      @(negedge clk);
      check("s5_busy_done", 32'(busy_o), 0);
      check("s5_valid_clr", 32'(valid_o), 0);
      q_idx.delete(); q_ev.delete();
      do_req(1); idle(3);
      check("s5_post_idx", 32'(q_idx[0]), 0); check("s5_post_ev", 32'(q_ev[0]), 0);

      // Inval then refill; inval racing an allocation of the same way.
      do_reset(); do_req(4); idle(3);
      inval_v = 1'b1; inval_way = 4'b0100; step(); inval_v = 1'b0;
      do_req(1); idle(3);
      check("s6_idx", 32'(q_idx[4]), 2); check("s6_ev", 32'(q_ev[4]), 0);
      lock = 4'b0111; inval_v = 1'b1; inval_way = 4'b1000;
      do_req(1); inval_v = 1'b0; lock = '0; idle(3);
      check("s6_race_idx", 32'(q_idx[5]), 3);
      @(negedge clk); check("s6_valid3", 32'(valid_o[3]), 1); step();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         req_v     = ($urandom % 4) != 0;
         rsp_rdy   = ($urandom % 4) != 0;
         flush_i   = ($urandom % 40) == 0;
         hit_v     = ($urandom % 3) == 0;
         hit_way   = 4'b0001 << ($urandom % 4);
         inval_v   = ($urandom % 8) == 0;
         inval_way = 4'b0001 << ($urandom % 4);
         lock      = (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000;
         if (($urandom % 500) == 0) do_reset();
         else step();
      end
      req_v = 0; flush_i = 0; hit_v = 0; inval_v = 0; lock = '0;
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
